// File: rtl/psum_row_collector_if.sv
// Bus between the MAC array's south edge, the row collector and the downstream row writer.
// Handshake: a row is popped on a rising edge exactly when rd and o_valid are both high.
interface psum_row_collector_if #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16
);
  logic [PSUM_BW*COL-1:0] in_s;
  logic [COL-1:0]         valid_in;
  logic                   flush;
  logic                   rd;
  logic                   o_valid;
  logic [PSUM_BW*COL-1:0] out;
  logic                   o_full;
  logic                   o_ready;
  logic                   overflow;

  modport master (
    output in_s, valid_in, flush, rd,
    input  o_valid, out, o_full, o_ready, overflow
  );

  modport slave (
    input  in_s, valid_in, flush, rd,
    output o_valid, out, o_full, o_ready, overflow
  );
endinterface

// File: rtl/psum_row_collector.sv
// Per-column FIFOs that de-skew the array's diagonal psum stream and present
// column-aligned rows with first-word fall-through.
module psum_row_collector #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int DEPTH   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  psum_row_collector_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PSUM_BW-1:0]     mem_q [COL][DEPTH];
  logic [AW-1:0]          wptr_q [COL];
  logic [AW-1:0]          rptr_q [COL];
  logic [CW-1:0]          cnt_q [COL];
  logic [CW-1:0]          cnt_d [COL];
  logic                   overflow_q;
  logic                   overflow_d;
  logic [COL-1:0]         nonempty;
  logic [COL-1:0]         full;
  logic [COL-1:0]         wr_acc;
  logic                   row_valid;
  logic                   pop;
  logic [PSUM_BW*COL-1:0] out_w;

  always_comb begin
    for (int c = 0; c < COL; c++) begin
      nonempty[c] = (cnt_q[c] != '0);
      full[c]     = (cnt_q[c] == FULL_CNT);
    end
  end

  assign row_valid = &nonempty;
  assign pop       = bus.rd & row_valid & ~bus.flush;

  // A full column still accepts a write when the row pop frees a slot in the same cycle.
  always_comb begin
    overflow_d = overflow_q;
    for (int c = 0; c < COL; c++) begin
      wr_acc[c] = bus.valid_in[c] & ~bus.flush & (~full[c] | pop);
      if (bus.valid_in[c] & ~bus.flush & full[c] & ~pop) begin
        overflow_d = 1'b1;
      end
      cnt_d[c] = cnt_q[c] + CW'(wr_acc[c]) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < COL; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      for (int c = 0; c < COL; c++) begin
        if (bus.flush) begin
          wptr_q[c] <= '0;
          rptr_q[c] <= '0;
          cnt_q[c]  <= '0;
        end else begin
          if (wr_acc[c]) wptr_q[c] <= wptr_q[c] + 1'b1;
          if (pop)       rptr_q[c] <= rptr_q[c] + 1'b1;
          cnt_q[c] <= cnt_d[c];
        end
      end
    end
  end

  // Storage carries no reset; emptiness is tracked purely by the counts.
  always_ff @(posedge clk) begin
    for (int c = 0; c < COL; c++) begin
      if (wr_acc[c]) begin
        mem_q[c][wptr_q[c]] <= bus.in_s[c*PSUM_BW +: PSUM_BW];
      end
    end
  end

  always_comb begin
    out_w = '0;
    for (int c = 0; c < COL; c++) begin
      out_w[c*PSUM_BW +: PSUM_BW] = row_valid ? mem_q[c][rptr_q[c]] : '0;
    end
  end

  assign bus.o_valid  = row_valid;
  assign bus.out      = out_w;
  assign bus.o_full   = |full;
  assign bus.o_ready  = ~(|full);
  assign bus.overflow = overflow_q;
endmodule
